div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
- Sequencing controller between the EX stage and the shared iterative 32-bit divider.
- Accepts DIV/DIVU requests from EX and launches the divider with latched operands.
- Stalls the pipeline until the divider's result is ready, then delivers the HI/LO writeback as a one-cycle pulse.
- Handles flush/annul and divider recovery, and watches the divider with a timeout.

Parameters:
TIMEOUT_CYCLES, 64, maximum BUSY cycles without div_ready_i before the controller aborts and flags an error
DRAIN_CYCLES, 2, cycles spent in DRAIN with start and annul handling before returning to IDLE (minimum 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
div_req_i  in  1  EX holds a divide instruction (held while stalled)
div_signed_i  in  1  1 = DIV (signed), 0 = DIVU
div_op1_i  in  32  dividend
div_op2_i  in  32  divisor
flush_i  in  1  pipeline flush; kills an in-flight divide
div_start_o  out  1  divider start; held high until the result is taken
div_annul_o  out  1  divider annul
div_signed_o  out  1  latched signedness to divider
div_opdata1_o  out  32  latched dividend to divider
div_opdata2_o  out  32  latched divisor to divider
div_result_i  in  64  divider result: [63:32] remainder, [31:0] quotient
div_ready_i  in  1  divider result valid
stall_o  out  1  stall request to the pipeline control
hi_o  out  32  remainder of the last completed divide
lo_o  out  32  quotient of the last completed divide
hilo_we_o  out  1  one-cycle HI/LO write pulse
busy_o  out  1  controller not IDLE
timeout_o  out  1  sticky; set on watchdog expiry, cleared only by rst

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; all outputs 0, including hi_o, lo_o and timeout_o; counters 0. Reset mid-operation abandons the divide with no writeback. The divider is reset by the same rst.
- State IDLE:
  - div_req_i=1 and flush_i=0: latch signed/op1/op2 into the operand registers and go BUSY.
  - stall_o is combinational: it equals div_req_i & ~flush_i in IDLE, so the requesting instruction is stalled in the same cycle.
- State BUSY:
  - div_start_o=1, stall_o=1. Operand outputs come from the registers and are stable for the whole operation.
  - A cycle counter increments every BUSY cycle.
  - Priority is flush_i, then div_ready_i, then timeout.
  - flush_i=1: div_annul_o=1 and div_start_o=0 in that cycle; go DRAIN; no hilo_we_o.
  - div_ready_i=1: register hi_o=div_result_i[63:32] and lo_o=div_result_i[31:0]; go DONE.
  - Counter reaches TIMEOUT_CYCLES: set timeout_o, hi_o=lo_o=0, go DONE so the pipeline cannot deadlock.
- State DONE (one cycle):
  - hilo_we_o=1, stall_o=0, div_start_o=0. Dropping start releases the divider to its free state.
  - div_req_i seen in DONE belongs to the retiring instruction and is ignored.
  - Next state is IDLE.
- State DRAIN:
  - div_start_o=0, stall_o=0.
  - div_annul_o=1 for the first DRAIN cycle, 0 afterwards.
  - Requests are not accepted. Stay DRAIN_CYCLES cycles, then go IDLE.
- Latency: request to hilo_we_o is (divider latency) + 2 cycles.
- flush_i in IDLE: no launch. flush_i in DONE: the writeback still occurs, because the instruction has already retired past EX.
- hi_o/lo_o hold their value until the next completion.

Optional Feature:
DIV_ZERO_FAST_EN
- Defined: in IDLE, a request with div_op2_i==0 does not start the divider. The controller goes directly to DONE with hi_o=0 and lo_o=0; hilo_we_o fires 1 cycle after the request.
- Undefined: divide-by-zero goes through the divider like any other operand pair; result 0/0 via the divider's zero path.

Test Plan:
- DIVU 100/7 -> div_start_o held until div_ready_i; hilo_we_o pulses once with lo_o=14, hi_o=2; stall_o drops in the DONE cycle.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; div_signed_o=1 throughout BUSY.
- flush_i asserted 10 cycles into BUSY -> div_annul_o=1 for 2 cycles (flush cycle plus first DRAIN cycle), no hilo_we_o, hi_o/lo_o unchanged; a DIVU 9/3 issued after DRAIN gives lo_o=3, hi_o=0.
- DIVU 5/0 -> without macro: completes via divider, hi_o=lo_o=0; with DIV_ZERO_FAST_EN: hilo_we_o 1 cycle after request, div_start_o never asserted.
- Divider model holds div_ready_i=0 -> after 64 BUSY cycles timeout_o=1, hilo_we_o pulses with 0/0, stall_o released; timeout_o stays 1 until rst.
- Back-to-back DIVU 20/3 then 20/6 -> two separate pulses: (lo=6, hi=2) then (lo=3, hi=2); the second is launched only from IDLE after DONE.

Source files
------------

// File: rtl/div_issue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : div_issue_ctrl
// Description : Sequencer between the EX stage and the shared iterative
//               32-bit divider. Latches DIV/DIVU operands, holds the divider
//               start, stalls the pipeline until the result is ready, then
//               pulses the HI/LO writeback for one cycle. Handles flush/annul,
//               a post-flush drain window and a watchdog timeout.
// Ports       : clk, rst (sync, active-high)
//               div_req_i/div_signed_i/div_op1_i/div_op2_i : request from EX
//               flush_i                                    : pipeline flush
//               div_start_o/div_annul_o/div_signed_o/
//               div_opdata1_o/div_opdata2_o                : to divider
//               div_result_i/div_ready_i                   : from divider
//               stall_o, hi_o, lo_o, hilo_we_o             : to pipeline
//               busy_o, timeout_o (sticky)                 : status
// Options     : `define DIV_ZERO_FAST_EN - divide-by-zero completes in one
//               cycle without starting the divider (result 0/0).
// Revision    : 1.0 - initial release
// ============================================================================
module div_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int DRAIN_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_req_i,
    input  logic        div_signed_i,
    input  logic [31:0] div_op1_i,
    input  logic [31:0] div_op2_i,
    input  logic        flush_i,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_opdata1_o,
    output logic [31:0] div_opdata2_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        stall_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        hilo_we_o,
    output logic        busy_o,
    output logic        timeout_o
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_BUSY  = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;
    localparam logic [1:0] c_DRAIN = 2'd3;

    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_DRN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_DRN_W-1:0] c_DRN_LAST = c_DRN_W'(DRAIN_CYCLES - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_signed;
    logic [31:0]        r_op1;
    logic [31:0]        r_op2;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_DRN_W-1:0] r_drn;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic               r_timeout;

    logic w_accept;
    logic w_zero_fast;
    logic w_timeout_hit;

    assign w_accept = (r_state == c_IDLE) && div_req_i && !flush_i;

`ifdef DIV_ZERO_FAST_EN
    assign w_zero_fast = (div_op2_i == 32'd0);
`else
    assign w_zero_fast = 1'b0;
`endif

    // r_cnt holds the number of BUSY cycles already completed, so this is
    // true during the TIMEOUT_CYCLES-th BUSY cycle.
    assign w_timeout_hit = (r_cnt == c_CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_zero_fast ? c_DONE : c_BUSY;
                end
            end
            c_BUSY: begin
                if (flush_i) begin
                    w_state_nxt = c_DRAIN;
                end else if (div_ready_i || w_timeout_hit) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                w_state_nxt = c_IDLE;
            end
            c_DRAIN: begin
                if (r_drn == c_DRN_LAST) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        div_start_o = 1'b0;
        div_annul_o = 1'b0;
        stall_o     = 1'b0;
        hilo_we_o   = 1'b0;
        busy_o      = (r_state != c_IDLE);
        case (r_state)
            c_IDLE: begin
                // Combinational so the requester stalls in its own cycle.
                stall_o = div_req_i && !flush_i;
            end
            c_BUSY: begin
                stall_o     = 1'b1;
                div_start_o = !flush_i;
                div_annul_o = flush_i;
            end
            c_DONE: begin
                hilo_we_o = 1'b1;
            end
            c_DRAIN: begin
                div_annul_o = (r_drn == '0);
            end
            default: begin
                stall_o = 1'b0;
            end
        endcase
    end

    // Operand latches, counters and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_signed  <= 1'b0;
            r_op1     <= 32'd0;
            r_op2     <= 32'd0;
            r_cnt     <= '0;
            r_drn     <= '0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_signed <= div_signed_i;
                        r_op1    <= div_op1_i;
                        r_op2    <= div_op2_i;
                        r_cnt    <= '0;
                        if (w_zero_fast) begin
                            r_hi <= 32'd0;
                            r_lo <= 32'd0;
                        end
                    end
                end
                c_BUSY: begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (flush_i) begin
                        r_drn <= '0;
                    end else if (div_ready_i) begin
                        r_hi <= div_result_i[63:32];
                        r_lo <= div_result_i[31:0];
                    end else if (w_timeout_hit) begin
                        r_timeout <= 1'b1;
                        r_hi      <= 32'd0;
                        r_lo      <= 32'd0;
                    end
                end
                c_DRAIN: begin
                    r_drn <= r_drn + c_DRN_W'(1);
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign div_signed_o  = r_signed;
    assign div_opdata1_o = r_op1;
    assign div_opdata2_o = r_op2;
    assign hi_o          = r_hi;
    assign lo_o          = r_lo;
    assign timeout_o     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_div_issue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_div_issue_ctrl
// Description : Self-checking bench for div_issue_ctrl with a behavioural
//               iterative-divider model and an expected-result queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_issue_ctrl;

    localparam int c_LAT     = 4;
    localparam int c_TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_req;
    logic        div_signed;
    logic [31:0] div_op1;
    logic [31:0] div_op2;
    logic        flush;
    logic        div_start;
    logic        div_annul;
    logic        div_signed_q;
    logic [31:0] div_opdata1;
    logic [31:0] div_opdata2;
    logic [63:0] div_result;
    logic        div_ready;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        hilo_we;
    logic        busy;
    logic        timeout;

    logic        hang;
    int          mdl_cnt;
    int          passed = 0;
    int          total  = 0;
    logic [63:0] sb[$];

    div_issue_ctrl #(.TIMEOUT_CYCLES(c_TIMEOUT), .DRAIN_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .div_req_i(div_req), .div_signed_i(div_signed),
        .div_op1_i(div_op1), .div_op2_i(div_op2), .flush_i(flush),
        .div_start_o(div_start), .div_annul_o(div_annul),
        .div_signed_o(div_signed_q), .div_opdata1_o(div_opdata1),
        .div_opdata2_o(div_opdata2), .div_result_i(div_result),
        .div_ready_i(div_ready), .stall_o(stall), .hi_o(hi), .lo_o(lo),
        .hilo_we_o(hilo_we), .busy_o(busy), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] div_calc(logic s, logic [31:0] a, logic [31:0] b);
        if (b == 32'd0) return 64'd0;
        if (s) return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
        return {a % b, a / b};
    endfunction

    // Divider model: result ready c_LAT cycles after start, held while start
    // stays high, cleared when start drops.
    always @(posedge clk) begin
        if (rst || !div_start) begin
            mdl_cnt    <= 0;
            div_ready  <= 1'b0;
            div_result <= 64'd0;
        end else if (!hang) begin
            if (mdl_cnt == c_LAT - 1) begin
                div_ready  <= 1'b1;
                div_result <= div_calc(div_signed_q, div_opdata1, div_opdata2);
            end else begin
                mdl_cnt <= mdl_cnt + 1;
            end
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
        div_req    = 1'b1;
        div_signed = s;
        div_op1    = a;
        div_op2    = b;
        #1;
        chk1("stall_same_cycle", stall, 1'b1);
    endtask

    // Step until the writeback pulse; every intervening BUSY cycle must hold
    // start/stall high with stable operands. Pops and checks the scoreboard.
    task automatic wait_wb(input int budget, input logic es, input logic [31:0] e1,
                           input logic [31:0] e2, output int cycles, output logic start_seen);
        logic        bad;
        logic [63:0] exp;
        bad        = 1'b0;
        start_seen = 1'b0;
        cycles     = 0;
        forever begin
            @(negedge clk);
            cycles++;
            if (hilo_we || cycles >= budget) break;
            if (busy) begin
                start_seen = start_seen | div_start;
                if (!(div_start && stall && div_signed_q == es &&
                      div_opdata1 == e1 && div_opdata2 == e2)) bad = 1'b1;
            end
        end
        chk1("wb_pulse_seen", hilo_we, 1'b1);
        chk1("busy_hold", bad, 1'b0);
        chk1("done_stall_low", stall, 1'b0);
        chk1("done_start_low", div_start, 1'b0);
        if (sb.size() == 0) begin
            total++;
            $error("FAIL sb_empty: observed writeback, expected none queued");
        end else begin
            exp = sb.pop_front();
            chk32("hi", hi, exp[63:32]);
            chk32("lo", lo, exp[31:0]);
        end
    endtask

    task automatic finish_wb();
        div_req = 1'b0;
        @(negedge clk);
        chk1("single_pulse", hilo_we, 1'b0);
        chk1("back_idle", busy, 1'b0);
    endtask

    initial begin
        int   cyc;
        logic ss;
        logic we_seen;

        rst = 1'b1; div_req = 1'b0; div_signed = 1'b0; div_op1 = 32'd0;
        div_op2 = 32'd0; flush = 1'b0; hang = 1'b0;
        repeat (2) @(negedge clk);
        chk1("rst_stall", stall, 1'b0);
        chk1("rst_start", div_start, 1'b0);
        chk1("rst_annul", div_annul, 1'b0);
        chk1("rst_we", hilo_we, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_timeout", timeout, 1'b0);
        chk32("rst_hi", hi, 32'd0);
        chk32("rst_lo", lo, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // DIVU 100/7
        issue(1'b0, 32'd100, 32'd7);
        sb.push_back({32'd2, 32'd14});
        wait_wb(50, 1'b0, 32'd100, 32'd7, cyc, ss);
        chk32("divu_latency", cyc, 32'(c_LAT + 2));
        finish_wb();

        // DIV -7/2
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        sb.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
        wait_wb(50, 1'b1, 32'hFFFF_FFF9, 32'd2, cyc, ss);
        finish_wb();

        // Flush 10 cycles into BUSY
        hang = 1'b1;
        issue(1'b0, 32'd50, 32'd5);
        we_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            we_seen = we_seen | hilo_we;
        end
        chk1("flush_pre_busy", busy, 1'b1);
        chk1("flush_pre_start", div_start, 1'b1);
        flush = 1'b1; div_req = 1'b0;
        #1;
        chk1("flush_annul", div_annul, 1'b1);
        chk1("flush_start", div_start, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        we_seen = we_seen | hilo_we;
        chk1("drain1_annul", div_annul, 1'b1);
        chk1("drain1_stall", stall, 1'b0);
        chk1("drain1_busy", busy, 1'b1);
        @(negedge clk);
        we_seen = we_seen | hilo_we;
        chk1("drain2_annul", div_annul, 1'b0);
        hang = 1'b0;
        issue_drain: begin
            div_req = 1'b1; div_signed = 1'b0; div_op1 = 32'd9; div_op2 = 32'd3;
            #1;
            chk1("drain_no_accept", stall, 1'b0);
        end
        chk1("flush_no_we", we_seen, 1'b0);
        chk32("flush_hi_kept", hi, 32'hFFFF_FFFF);
        chk32("flush_lo_kept", lo, 32'hFFFF_FFFD);
        sb.push_back({32'd0, 32'd3});
        @(negedge clk);
        chk1("post_drain_idle", busy, 1'b0);
        chk1("post_drain_stall", stall, 1'b1);
        wait_wb(50, 1'b0, 32'd9, 32'd3, cyc, ss);
        finish_wb();

        // DIVU 5/0
        issue(1'b0, 32'd5, 32'd0);
        sb.push_back(64'd0);
        wait_wb(50, 1'b0, 32'd5, 32'd0, cyc, ss);
`ifdef DIV_ZERO_FAST_EN
        chk32("div0_latency", cyc, 32'd1);
        chk1("div0_no_start", ss, 1'b0);
`else
        chk32("div0_latency", cyc, 32'(c_LAT + 2));
        chk1("div0_start", ss, 1'b1);
`endif
        finish_wb();

        // Back-to-back DIVU 20/3 then 20/6
        issue(1'b0, 32'd20, 32'd3);
        sb.push_back({32'd2, 32'd6});
        wait_wb(50, 1'b0, 32'd20, 32'd3, cyc, ss);
        div_op2 = 32'd6;
        sb.push_back({32'd2, 32'd3});
        #1;
        chk1("b2b_done_stall", stall, 1'b0);
        @(negedge clk);
        chk1("b2b_idle", busy, 1'b0);
        chk1("b2b_idle_stall", stall, 1'b1);
        wait_wb(50, 1'b0, 32'd20, 32'd6, cyc, ss);
        chk32("b2b_latency", cyc, 32'(c_LAT + 2));
        finish_wb();

        // Watchdog timeout
        chk1("pre_timeout", timeout, 1'b0);
        hang = 1'b1;
        issue(1'b0, 32'd1, 32'd1);
        sb.push_back(64'd0);
        wait_wb(200, 1'b0, 32'd1, 32'd1, cyc, ss);
        chk32("timeout_latency", cyc, 32'(c_TIMEOUT + 1));
        chk1("timeout_set", timeout, 1'b1);
        finish_wb();
        hang = 1'b0;
        issue(1'b0, 32'd8, 32'd2);
        sb.push_back({32'd0, 32'd4});
        wait_wb(50, 1'b0, 32'd8, 32'd2, cyc, ss);
        finish_wb();
        chk1("timeout_sticky", timeout, 1'b1);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk1("rst2_timeout", timeout, 1'b0);
        chk32("rst2_lo", lo, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
